// File: rtl/uart_phase_array.sv
// uart_phase_array: UART-commanded 8x8 ultrasonic array with a movable 4x4
// window and a common carrier phase delay. Received bytes are echoed on TX.

// One grid row: enables the columns of this row that fall inside the window.
module uart_phase_lane #(
  parameter int ROW = 0
) (
  input  logic [2:0] pos_x,
  input  logic [2:0] pos_y,
  input  logic       level,
  output logic [7:0] bits
);
  logic row_en;
  assign row_en = (3'(ROW) >= pos_x) && (3'(ROW) <= pos_x + 3'd3);

  for (genvar c = 0; c < 8; c++) begin : g_col
    assign bits[c] = level & row_en & (3'(c) >= pos_y) & (3'(c) <= pos_y + 3'd3);
  end
endmodule

module uart_phase_array #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [63:0] wav,
  output logic [2:0]  pos_x,
  output logic [2:0]  pos_y,
  output logic [9:0]  phase_delay,
  output logic        led_1,
  output logic        led_2
);
  localparam int CW   = $clog2(BAUD_DIV + 1);
  localparam int HALF = BAUD_DIV / 2;

  // ---------------- UART RX ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t       rstate;
  logic            rx_s1, rx_s2, rx_q;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_data;
  logic            rx_valid;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  // Receiver: start re-check at half bit, then mid-bit samples, LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate   <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rstate)
        R_IDLE: if (rx_q && !rx_s2) begin
          rx_cnt <= '0;
          rstate <= R_START;
        end
        R_START: if (rx_cnt == CW'(HALF - 1)) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rstate <= rx_s2 ? R_IDLE : R_DATA;   // high here means a glitch
        end else rx_cnt <= rx_cnt + 1'b1;
        R_DATA: if (rx_cnt == CW'(BAUD_DIV - 1)) begin
          rx_cnt  <= '0;
          rx_data <= {rx_s2, rx_data[7:1]};
          if (rx_bit == 3'd7) rstate <= R_STOP;
          else                rx_bit <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_STOP: if (rx_cnt == CW'(BAUD_DIV - 1)) begin
          rx_cnt   <= '0;
          rx_valid <= rx_s2;                   // framing error drops the byte
          rstate   <= R_IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- UART TX (echo) ----------------
  logic            tx_busy;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bits;
  logic [8:0]      tx_shift;

  // Transmitter: start bit goes out the cycle after rx_valid; busy drops echoes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '1;
      uart_tx  <= 1'b1;
    end else if (!tx_busy) begin
      if (rx_valid) begin
        tx_busy  <= 1'b1;
        tx_cnt   <= '0;
        tx_bits  <= '0;
        tx_shift <= {1'b1, rx_data};
        uart_tx  <= 1'b0;
      end
    end else if (tx_cnt == CW'(BAUD_DIV - 1)) begin
      tx_cnt <= '0;
      if (tx_bits == 4'd9) begin
        tx_busy <= 1'b0;
        uart_tx <= 1'b1;
      end else begin
        uart_tx  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bits  <= tx_bits + 1'b1;
      end
    end else tx_cnt <= tx_cnt + 1'b1;
  end

  // ---------------- Frame parser ----------------
  typedef enum logic [1:0] {P_IDLE, P_DIR, P_PH, P_END} p_state_t;
  p_state_t   pstate;
  logic [7:0] dir, ph;

  // FF dir ph 3C frames; window move saturates at 0 and 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      pstate      <= P_IDLE;
      dir         <= '0;
      ph          <= '0;
      pos_x       <= 3'd2;
      pos_y       <= 3'd2;
      phase_delay <= '0;
      led_1       <= 1'b0;
      led_2       <= 1'b0;
    end else if (rx_valid) begin
      case (pstate)
        P_IDLE: if (rx_data == 8'hFF) begin
          pstate <= P_DIR;
          led_1  <= 1'b1;
        end else led_2 <= 1'b1;
        P_DIR: begin
          dir    <= rx_data;
          pstate <= P_PH;
        end
        P_PH: begin
          ph     <= rx_data;
          pstate <= P_END;
        end
        P_END: begin
          led_1  <= 1'b0;
          led_2  <= 1'b1;
          pstate <= P_IDLE;
          if (rx_data == 8'h3C) begin
            phase_delay <= {ph, 2'b00};
            case (dir)
              8'h41: if (pos_x != 3'd0) pos_x <= pos_x - 1'b1;
              8'h44: if (pos_x != 3'd4) pos_x <= pos_x + 1'b1;
              8'h57: if (pos_y != 3'd0) pos_y <= pos_y - 1'b1;
              8'h53: if (pos_y != 3'd4) pos_y <= pos_y + 1'b1;
              default: ;
            endcase
          end
        end
        default: pstate <= P_IDLE;
      endcase
    end
  end

  // ---------------- Waveform ----------------
  logic [9:0]      cnt;
  logic            level;
  logic [7:0][7:0] row_bits;

  // Carrier MSB of the phase-shifted counter; high for exactly 512 of 1024.
  assign level = |(10'(cnt + phase_delay) & 10'h200);

  for (genvar r = 0; r < 8; r++) begin : g_row
    uart_phase_lane #(.ROW(r)) u_lane (
      .pos_x (pos_x),
      .pos_y (pos_y),
      .level (level),
      .bits  (row_bits[r])
    );
  end

  // Free-running carrier counter and registered drive outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wav <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      wav <= row_bits;
    end
  end
endmodule

// File: tb/tb_uart_phase_array.sv
// Directed bench for uart_phase_array with a short baud divisor.
module tb_uart_phase_array;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [63:0] wav;
  logic [2:0]  pos_x, pos_y;
  logic [9:0]  phase_delay;
  logic        led_1, led_2;

  int total = 0;
  int bad   = 0;

  logic [7:0] echo_q[$];
  int         echo_frm_bad = 0;
  logic [9:0] tb_cnt;

  uart_phase_array #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx), .wav(wav),
    .pos_x(pos_x), .pos_y(pos_y), .phase_delay(phase_delay),
    .led_1(led_1), .led_2(led_2)
  );

  always #5 clk = ~clk;

  // Reference carrier counter: cleared while rst, counts otherwise.
  always @(posedge clk) begin
    if (rst) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 10'd1;
  end

  // Echo decoder: collects bytes seen on uart_tx.
  initial begin
    logic [7:0] b;
    logic       s0, sp;
    forever begin
      @(negedge uart_tx);
      if (rst) continue;
      repeat (BD/2) @(negedge clk);
      s0 = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (BD) @(negedge clk);
      sp = uart_tx;
      if (s0 == 1'b0) echo_q.push_back(b);
      if (sp !== 1'b1 || s0 !== 1'b0) echo_frm_bad++;
    end
  end

  function automatic logic [63:0] exp_wav(int px, int py, int pd, int k);
    logic [63:0] w = '0;
    logic s = ((((k - 1 + pd) % 1024) + 1024) % 1024) >= 512;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (r >= px && r <= px + 3 && c >= py && c <= py + 3) w[r*8+c] = s;
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int gap_bits);
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (BD) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (gap_bits * BD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1, 12);
    send_byte(b1, 1'b1, 12);
    send_byte(b2, 1'b1, 12);
    send_byte(b3, 1'b1, 12);
  endtask

  // One full carrier period against the model; counts wrong cycles.
  task automatic check_period(input string nm, input int px, input int py, input int pd);
    int errs = 0;
    logic [63:0] e;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      e = exp_wav(px, py, pd, int'(tb_cnt));
      if (wav !== e) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s: %0d wrong cycles, required 0 (last wav=%h exp=%h)", nm, errs, wav, e);
    end
  endtask

  task automatic test_reset();
    int hi18 = 0, hi0 = 0, first_rise = -1;
    do_reset();
    total++;
    if (pos_x !== 3'd2 || pos_y !== 3'd2) begin
      bad++; $display("FAIL reset_pos: got (%0d,%0d) required (2,2)", pos_x, pos_y);
    end
    total++;
    if (phase_delay !== 10'd0) begin
      bad++; $display("FAIL reset_phase: got %0d required 0", phase_delay);
    end
    total++;
    if (wav !== 64'd0) begin
      bad++; $display("FAIL reset_wav: got %h required 0", wav);
    end
    total++;
    if (uart_tx !== 1'b1 || led_1 !== 1'b0 || led_2 !== 1'b0) begin
      bad++; $display("FAIL reset_io: tx=%b led1=%b led2=%b required 1 0 0", uart_tx, led_1, led_2);
    end
    // Row 2 col 2 goes high after 513 cycles (cnt 512 registered).
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (wav[18] === 1'b1 && first_rise < 0) first_rise = i;
    end
    total++;
    if (first_rise !== 513) begin
      bad++; $display("FAIL reset_first_rise: got %0d required 513", first_rise);
    end
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (wav[18] === 1'b1) hi18++;
      if (wav[0]  !== 1'b0) hi0++;
    end
    total++;
    if (hi18 !== 512 || hi0 !== 0) begin
      bad++; $display("FAIL reset_duty: bit18 high %0d required 512, bit0 high %0d required 0", hi18, hi0);
    end
    check_period("reset_window", 2, 2, 0);
  endtask

  task automatic test_move_phase();
    logic [7:0] sent[4];
    sent[0] = 8'hFF; sent[1] = 8'h41; sent[2] = 8'h40; sent[3] = 8'h3C;
    echo_q.delete();
    echo_frm_bad = 0;
    send_byte(sent[0], 1'b1, 12);
    total++;
    if (led_1 !== 1'b1) begin
      bad++; $display("FAIL frame_led1: got %b required 1", led_1);
    end
    for (int i = 1; i < 4; i++) send_byte(sent[i], 1'b1, 12);
    total++;
    if (pos_x !== 3'd1 || pos_y !== 3'd2 || phase_delay !== 10'd256) begin
      bad++; $display("FAIL move_phase: got (%0d,%0d,%0d) required (1,2,256)", pos_x, pos_y, phase_delay);
    end
    total++;
    if (led_1 !== 1'b0 || led_2 !== 1'b1) begin
      bad++; $display("FAIL move_leds: led1=%b led2=%b required 0 1", led_1, led_2);
    end
    total++;
    if (echo_q.size() !== 4 || echo_frm_bad !== 0) begin
      bad++; $display("FAIL echo_count: got %0d bytes, %0d bad frames; required 4, 0", echo_q.size(), echo_frm_bad);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (echo_q[i] !== sent[i]) begin
          bad++; $display("FAIL echo_byte%0d: got %h required %h", i, echo_q[i], sent[i]);
        end
      end
    end
    check_period("phase_256_window", 1, 2, 256);
  endtask

  task automatic test_saturation();
    logic [2:0] exp_x[4];
    logic [2:0] exp_y[3];
    exp_x[0] = 3'd3; exp_x[1] = 3'd4; exp_x[2] = 3'd4; exp_x[3] = 3'd4;
    exp_y[0] = 3'd1; exp_y[1] = 3'd0; exp_y[2] = 3'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'hFF, 8'h44, 8'h00, 8'h3C);
      total++;
      if (pos_x !== exp_x[i]) begin
        bad++; $display("FAIL sat_x%0d: got %0d required %0d", i, pos_x, exp_x[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      send_frame(8'hFF, 8'h57, 8'h00, 8'h3C);
      total++;
      if (pos_y !== exp_y[i]) begin
        bad++; $display("FAIL sat_y%0d: got %0d required %0d", i, pos_y, exp_y[i]);
      end
    end
    check_period("sat_window", 4, 0, 0);
  endtask

  task automatic test_bad_term();
    do_reset();
    send_frame(8'hFF, 8'h53, 8'h10, 8'h3D);
    total++;
    if (pos_x !== 3'd2 || pos_y !== 3'd2 || phase_delay !== 10'd0) begin
      bad++; $display("FAIL bad_term_nochange: got (%0d,%0d,%0d) required (2,2,0)", pos_x, pos_y, phase_delay);
    end
    total++;
    if (led_1 !== 1'b0 || led_2 !== 1'b1) begin
      bad++; $display("FAIL bad_term_leds: led1=%b led2=%b required 0 1", led_1, led_2);
    end
    send_frame(8'hFF, 8'h53, 8'h10, 8'h3C);
    total++;
    if (pos_x !== 3'd2 || pos_y !== 3'd3 || phase_delay !== 10'd64) begin
      bad++; $display("FAIL bad_term_recover: got (%0d,%0d,%0d) required (2,3,64)", pos_x, pos_y, phase_delay);
    end
  endtask

  task automatic test_noise();
    do_reset();
    echo_q.delete();
    send_byte(8'h55, 1'b0, 12);
    total++;
    if (echo_q.size() !== 0 || led_2 !== 1'b0) begin
      bad++; $display("FAIL framing_drop: echoes %0d led2=%b required 0 0", echo_q.size(), led_2);
    end
    send_byte(8'h00, 1'b1, 12);
    total++;
    if (led_2 !== 1'b1 || led_1 !== 1'b0 || echo_q.size() !== 1) begin
      bad++; $display("FAIL stray_byte: led2=%b led1=%b echoes %0d required 1 0 1", led_2, led_1, echo_q.size());
    end
    send_frame(8'hFF, 8'h53, 8'h00, 8'h3C);
    total++;
    if (pos_y !== 3'd3 || pos_x !== 3'd2) begin
      bad++; $display("FAIL stray_then_frame: got (%0d,%0d) required (2,3)", pos_x, pos_y);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'hFF, 1'b1, 12);
    send_byte(8'h41, 1'b1, 1);      // echo of 0x41 still on the line
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (uart_tx !== 1'b1 || led_1 !== 1'b0) begin
      bad++; $display("FAIL mid_reset_tx: tx=%b led1=%b required 1 0", uart_tx, led_1);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * BD) @(negedge clk);
    echo_q.delete();
    send_byte(8'h40, 1'b1, 12);
    send_byte(8'h3C, 1'b1, 12);
    total++;
    if (pos_x !== 3'd2 || pos_y !== 3'd2 || phase_delay !== 10'd0) begin
      bad++; $display("FAIL mid_reset_abort: got (%0d,%0d,%0d) required (2,2,0)", pos_x, pos_y, phase_delay);
    end
  endtask

  initial begin
    test_reset();
    test_move_phase();
    test_saturation();
    test_bad_term();
    test_noise();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
